// File: rtl/ram_data_port_arbiter.sv
// Registered request/grant arbiter sharing the RAM data port between the DMA
// unit and the pram copy engine. It applies the r_k relocation base and routes
// read data back to the requester that issued the read.
module ram_data_port_arbiter #(
  parameter int unsigned RAM_LATENCY = 1,  // 1..4
  parameter int unsigned MAX_WAIT    = 4   // 1..15
) (
  input  logic        physical_clock,
  input  logic        reset,
  input  logic [15:0] base_k,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic        dma_stack,
  input  logic [15:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  input  logic        pram_req,
  input  logic        pram_we,
  input  logic [15:0] pram_addr,
  input  logic [31:0] pram_wdata,
  output logic        pram_gnt,
  output logic        pram_rvalid,
  output logic [31:0] pram_rdata,
  output logic [15:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic        ram_we,
  input  logic [31:0] ram_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'b00,
    OWN_DMA  = 2'b01,
    OWN_PRAM = 2'b10
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e who;
  } tag_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  logic        dma_gnt_q, dma_gnt_d;
  logic        pram_gnt_q, pram_gnt_d;
  owner_e      owner_q, owner_d;
  logic        ram_we_q, ram_we_d;
  logic [15:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_wdata_q, ram_wdata_d;
  logic [3:0]  wait_q, wait_d;
  logic        dma_rvalid_q, dma_rvalid_d;
  logic        pram_rvalid_q, pram_rvalid_d;
  logic [31:0] dma_rdata_q, dma_rdata_d;
  logic [31:0] pram_rdata_q, pram_rdata_d;
  tag_t        tag_q [RAM_LATENCY];
  tag_t        tag_d [RAM_LATENCY];

  logic dma_elig, pram_elig, dma_win, pram_win;
  tag_t tag_exit;

  // Arbitration and command formation for the next cycle
  always_comb begin
    dma_elig  = dma_req & ~dma_gnt_q;
    pram_elig = pram_req & ~pram_gnt_q;
    pram_win  = pram_elig & (~dma_elig | (wait_q >= MAX_WAIT_C));
    dma_win   = dma_elig & ~pram_win;

    dma_gnt_d   = 1'b0;
    pram_gnt_d  = 1'b0;
    owner_d     = OWN_IDLE;
    ram_we_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;
    if (dma_win) begin
      dma_gnt_d   = 1'b1;
      owner_d     = OWN_DMA;
      ram_we_d    = dma_we;
      ram_wdata_d = dma_wdata;
      ram_addr_d  = dma_stack ? dma_addr : dma_addr + base_k;
    end else if (pram_win) begin
      pram_gnt_d  = 1'b1;
      owner_d     = OWN_PRAM;
      ram_we_d    = pram_we;
      ram_wdata_d = pram_wdata;
      ram_addr_d  = pram_addr + base_k;
    end

    wait_d = wait_q;
    if (pram_win || !pram_req) begin
      wait_d = '0;
    end else if (dma_win && wait_q != 4'hF) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // Read tag pipeline; stage 0 is loaded from the command currently on the port
  always_comb begin
    tag_d[0].valid = ~ram_we_q & (owner_q != OWN_IDLE);
    tag_d[0].who   = owner_q;
    for (int unsigned i = 1; i < RAM_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    tag_exit = tag_q[RAM_LATENCY-1];

    dma_rvalid_d  = tag_exit.valid & (tag_exit.who == OWN_DMA);
    pram_rvalid_d = tag_exit.valid & (tag_exit.who == OWN_PRAM);
    dma_rdata_d   = dma_rvalid_d  ? ram_rdata : dma_rdata_q;
    pram_rdata_d  = pram_rvalid_d ? ram_rdata : pram_rdata_q;
  end

  // State and output registers
  always_ff @(posedge physical_clock or posedge reset) begin
    if (reset) begin
      dma_gnt_q     <= 1'b0;
      pram_gnt_q    <= 1'b0;
      owner_q       <= OWN_IDLE;
      ram_we_q      <= 1'b0;
      ram_addr_q    <= '0;
      ram_wdata_q   <= '0;
      wait_q        <= '0;
      dma_rvalid_q  <= 1'b0;
      pram_rvalid_q <= 1'b0;
      dma_rdata_q   <= '0;
      pram_rdata_q  <= '0;
      tag_q         <= '{default: '0};
    end else begin
      dma_gnt_q     <= dma_gnt_d;
      pram_gnt_q    <= pram_gnt_d;
      owner_q       <= owner_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      wait_q        <= wait_d;
      dma_rvalid_q  <= dma_rvalid_d;
      pram_rvalid_q <= pram_rvalid_d;
      dma_rdata_q   <= dma_rdata_d;
      pram_rdata_q  <= pram_rdata_d;
      tag_q         <= tag_d;
    end
  end

  assign dma_gnt     = dma_gnt_q;
  assign pram_gnt    = pram_gnt_q;
  assign owner       = owner_q;
  assign ram_we      = ram_we_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign dma_rvalid  = dma_rvalid_q;
  assign pram_rvalid = pram_rvalid_q;
  assign dma_rdata   = dma_rdata_q;
  assign pram_rdata  = pram_rdata_q;

endmodule

// File: tb/tb_ram_data_port_arbiter.sv
// Scoreboard bench for ram_data_port_arbiter: a reference model predicts every
// command and read return; a monitor compares them as the DUT presents them.
module tb_ram_data_port_arbiter;

  localparam int L  = 1;
  localparam int MW = 4;

  logic        physical_clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] base_k = '0;
  logic        dma_req = 1'b0, dma_we = 1'b0, dma_stack = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [31:0] dma_wdata = '0;
  logic        pram_req = 1'b0, pram_we = 1'b0;
  logic [15:0] pram_addr = '0;
  logic [31:0] pram_wdata = '0;
  logic [31:0] ram_rdata = '0;
  logic        dma_gnt, dma_rvalid, pram_gnt, pram_rvalid, ram_we;
  logic [31:0] dma_rdata, pram_rdata, ram_wdata;
  logic [15:0] ram_addr;
  logic [1:0]  owner;

  ram_data_port_arbiter #(.RAM_LATENCY(L), .MAX_WAIT(MW)) dut (
    .physical_clock(physical_clock), .reset(reset), .base_k(base_k),
    .dma_req(dma_req), .dma_we(dma_we), .dma_stack(dma_stack),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata), .dma_gnt(dma_gnt),
    .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .pram_req(pram_req), .pram_we(pram_we), .pram_addr(pram_addr),
    .pram_wdata(pram_wdata), .pram_gnt(pram_gnt), .pram_rvalid(pram_rvalid),
    .pram_rdata(pram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .owner(owner)
  );

  always #5 physical_clock = ~physical_clock;

  typedef struct {
    int          cyc;
    logic [1:0]  own;
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [1:0]  own;
    logic [31:0] data;
  } rd_t;

  cmd_t        cmd_q[$];
  rd_t         rd_q[$];
  logic [31:0] rd_sched [int];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] last_d = '0, last_p = '0;

  // model state: who was granted at the most recent edge, and the wait count
  bit          m_dma_g = 0, m_pram_g = 0;
  int          m_wait = 0;
  bit          use_fixed = 0;
  logic [31:0] fixed_data = '0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void issue(logic [1:0] own, logic we, logic [15:0] addr, logic [31:0] wd);
    cmd_t c;
    rd_t  r;
    c.cyc = cyc; c.own = own; c.we = we; c.addr = addr; c.wdata = wd;
    cmd_q.push_back(c);
    if (!we) begin
      r.cyc  = cyc + L + 1;
      r.own  = own;
      r.data = use_fixed ? fixed_data : $urandom;
      rd_sched[cyc + L] = r.data;
      rd_q.push_back(r);
    end
  endfunction

  // Reference decision for one rising edge, from the inputs held before it
  function automatic void model_edge();
    bit want_d, want_p, take_p, take_d;
    logic [15:0] a;
    want_d = dma_req && !m_dma_g;
    want_p = pram_req && !m_pram_g;
    take_p = want_p && (!want_d || m_wait >= MW);
    take_d = want_d && !take_p;
    if (take_p || !pram_req) m_wait = 0;
    else if (take_d) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
    m_dma_g  = take_d;
    m_pram_g = take_p;
    if (take_d) begin
      a = dma_stack ? dma_addr : 16'((int'(dma_addr) + int'(base_k)) % 65536);
      issue(2'b01, dma_we, a, dma_wdata);
    end else if (take_p) begin
      a = 16'((int'(pram_addr) + int'(base_k)) % 65536);
      issue(2'b10, pram_we, a, pram_wdata);
    end
  endfunction

  task automatic tick();
    @(posedge physical_clock);
    cyc++;
    if (!reset) model_edge();
    #1;
    ram_rdata = rd_sched.exists(cyc) ? rd_sched[cyc] : $urandom;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic void model_reset();
    cmd_q.delete();
    rd_q.delete();
    rd_sched.delete();
    m_dma_g = 0; m_pram_g = 0; m_wait = 0;
    last_d = '0; last_p = '0;
  endfunction

  function automatic void rand_dma();
    dma_req = ($urandom_range(0, 99) < 60);
    dma_we = 1'($urandom); dma_stack = 1'($urandom);
    dma_addr = 16'($urandom); dma_wdata = $urandom;
  endfunction

  function automatic void rand_pram();
    pram_req = ($urandom_range(0, 99) < 60);
    pram_we = 1'($urandom);
    pram_addr = 16'($urandom); pram_wdata = $urandom;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued predictions
  initial begin
    cmd_t c;
    rd_t  r;
    forever begin
      @(negedge physical_clock);
      if (reset) begin
        chk("reset_outputs",
            {dma_gnt, dma_rvalid, dma_rdata, pram_gnt, pram_rvalid, pram_rdata,
             ram_addr, ram_wdata, ram_we, owner}, '0);
      end else begin
        if (dma_gnt || pram_gnt || ram_we || owner != 2'b00) begin
          if (cmd_q.size() == 0) chk("unexpected_cmd", 1, 0);
          else begin
            c = cmd_q.pop_front();
            chk("cmd", {cyc, dma_gnt, pram_gnt, owner, ram_we, ram_addr, ram_wdata},
                {c.cyc, c.own == 2'b01, c.own == 2'b10, c.own, c.we, c.addr, c.wdata});
          end
        end else begin
          chk("idle_cycle", {ram_addr, ram_wdata, cmd_q.size() > 0 && cmd_q[0].cyc == cyc}, '0);
        end
        if (dma_rvalid || pram_rvalid) begin
          if (rd_q.size() == 0) chk("unexpected_rvalid", 1, 0);
          else begin
            r = rd_q.pop_front();
            chk("rvalid", {cyc, dma_rvalid, pram_rvalid, pram_rvalid ? pram_rdata : dma_rdata},
                {r.cyc, r.own == 2'b01, r.own == 2'b10, r.data});
            if (r.own == 2'b01) last_d = r.data;
            else last_p = r.data;
          end
        end else begin
          chk("rvalid_missing", rd_q.size() > 0 && rd_q[0].cyc == cyc, 0);
        end
        chk("rdata_hold", {dma_rdata, pram_rdata}, {last_d, last_p});
      end
    end
  end

  // Stimulus
  initial begin
    ticks(3);
    reset = 1'b0;

    // single dma read, relocated, fixed return data
    base_k = 16'h0100; dma_req = 1; dma_we = 0; dma_stack = 0; dma_addr = 16'h0010;
    use_fixed = 1; fixed_data = 32'hDEADBEEF;
    tick();
    use_fixed = 0; dma_req = 0;
    ticks(4);

    // stack write: no base, no rvalid
    dma_req = 1; dma_we = 1; dma_stack = 1; dma_addr = 16'h7FF0; dma_wdata = 32'h12345678;
    tick();
    dma_req = 0; dma_we = 0; dma_stack = 0;
    ticks(3);

    // pram address wrap
    pram_req = 1; pram_we = 0; pram_addr = 16'hFFFF; base_k = 16'h0002;
    tick();
    pram_req = 0;
    ticks(4);

    // interleaved dma then pram reads
    base_k = 16'h0400; dma_req = 1; dma_we = 0; dma_addr = 16'h0020;
    tick();
    dma_req = 0; pram_req = 1; pram_we = 0; pram_addr = 16'h0030;
    tick();
    pram_req = 0;
    ticks(4);

    // both held high: contention
    dma_req = 1; pram_req = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      dma_we = 1'($urandom); dma_addr = 16'($urandom); dma_wdata = $urandom;
      pram_we = 1'($urandom); pram_addr = 16'($urandom); pram_wdata = $urandom;
    end
    dma_req = 0; pram_req = 0;
    ticks(4);

    // reset in the cycle after a dma read grant
    dma_req = 1; dma_we = 0; dma_stack = 0; dma_addr = 16'h0044;
    tick();
    dma_req = 0;
    tick();
    reset = 1'b1;
    model_reset();
    ticks(2);
    reset = 1'b0;
    ticks(4);

    // randomized traffic; a requester holds its request until granted
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!(dma_req && !m_dma_g)) rand_dma();
      if (!(pram_req && !m_pram_g)) rand_pram();
      base_k = 16'($urandom);
    end
    dma_req = 0; pram_req = 0;
    ticks(L + 4);

    chk("drain", {cmd_q.size(), rd_q.size()}, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_data_port_arbiter.md
Name: ram_data_port_arbiter

Overview:
- Shares the single data port of the dual-port RAM between two requesters: the DMA unit (CPU load/store/stack traffic) and the parallel RAM copy engine (pram).
- Replaces the combinational DMA_ENB steering with a registered request/grant arbiter.
- Applies the r_k base offset and returns read data to the correct owner.
- Sits between the DMA/pram engines and the RAM data port. The instruction port is untouched.

Parameters:
- RAM_LATENCY, 1, cycles from a command on ram_* until ram_rdata is valid (range 1..4).
- MAX_WAIT, 4, consecutive DMA wins while pram is requesting before pram is forced to win (range 1..15).

Ports:
- physical_clock  input  1  single clock for the block
- reset  input  1  asynchronous, active-high
- base_k  input  16  relocation base (r_k[15:0]); sampled in the grant cycle
- dma_req  input  1  DMA request; held until dma_gnt is seen
- dma_we  input  1  1 = write, 0 = read
- dma_stack  input  1  1 = physical address (no base added)
- dma_addr  input  16  logical address
- dma_wdata  input  32  write data
- dma_gnt  output  1  one-cycle grant pulse
- dma_rvalid  output  1  read data valid pulse
- dma_rdata  output  32  read data
- pram_req  input  1  pram request
- pram_we  input  1  write enable
- pram_addr  input  16  logical address (base always added)
- pram_wdata  input  32  write data
- pram_gnt  output  1  grant pulse
- pram_rvalid  output  1  read data valid pulse
- pram_rdata  output  32  read data
- ram_addr  output  16  RAM data-port address
- ram_wdata  output  32  RAM write data
- ram_we  output  1  RAM write strobe
- ram_rdata  input  32  RAM read data
- owner  output  2  00 idle, 01 dma, 10 pram (owner of the current command cycle)

Behaviour:
- All outputs are registered. On reset, every output is 0, the wait counter is 0 and the tag pipeline is empty.
- Arbitration is evaluated at every rising edge.
  - A requester is eligible if its req=1 and its gnt is not currently 1. This prevents a double grant while the requester drops req.
  - Exactly one eligible requester: it wins.
  - Both eligible: DMA wins, unless wait_cnt >= MAX_WAIT, in which case pram wins.
- Command cycle (the cycle after the winning edge):
  - the winner's gnt=1;
  - owner = winner;
  - ram_we = winner_we;
  - ram_wdata = winner_wdata;
  - ram_addr:
    - dma with dma_stack=1: dma_addr;
    - dma with dma_stack=0: dma_addr + base_k;
    - pram: pram_addr + base_k.
  - Address addition is 16-bit modulo (0xFFFF + 2 = 0x0001).
- Non-command cycles: ram_we=0, ram_addr=0, ram_wdata=0, owner=00, both gnt=0.
- Back-to-back commands are allowed:
  - one command per cycle;
  - the same requester can be granted at most every 2 cycles, because of the eligibility rule;
  - the other requester can be granted in the intervening cycle.
- wait_cnt (4-bit, saturating):
  - increments when DMA wins while pram_req=1;
  - clears when pram is granted or pram_req=0.
- Read return uses a tag pipeline RAM_LATENCY deep, carrying {valid, owner} for read commands only. Writes produce no rvalid.
  - When the tag exits, ram_rdata is registered into the owner's rdata and that owner's rvalid pulses for 1 cycle.
  - Read-to-rvalid latency: gnt in cycle T gives rvalid in cycle T+RAM_LATENCY+1. Default: T+2.
  - rdata holds its last value between pulses.
  - The other owner's rvalid stays 0.
- Requests are consumed in grant order. Returns are in command order; the pipeline is never stalled.
- Simultaneous read return and new grant are independent; both occur in the same cycle.
- Reset asserted mid-operation: in-flight reads are discarded, no rvalid is produced, the counter clears, and the block restarts arbitration from idle after reset release.
- Requester inputs are ignored while req=0. The block makes no assumption about input stability outside the winning edge.

Test Plan:
- Reset, then a single dma read: dma_req=1, dma_we=0, dma_addr=0x0010, base_k=0x0100, dma_stack=0 -> gnt next cycle with ram_addr=0x0110, ram_we=0. RAM returns 0xDEADBEEF -> dma_rvalid at T+2, dma_rdata=0xDEADBEEF, pram_rvalid=0.
- Stack write: dma_stack=1, addr 0x7FF0, wdata 0x12345678, base_k=0x0100 -> ram_addr=0x7FF0, ram_we=1 for exactly 1 cycle, no rvalid.
- Starvation: dma_req and pram_req held high continuously, MAX_WAIT=4 -> grant sequence dma, pram, dma, pram … (bounded by the eligibility rule). With a dma stream that re-asserts every cycle, pram is granted no later than after 4 DMA wins. Check that owner never shows two grants in the same cycle.
- Wrap: pram_addr=0xFFFF, base_k=0x0002 -> ram_addr=0x0001.
- Interleaved reads: dma read at T, pram read at T+1, RAM_LATENCY=1 -> dma_rvalid at T+2 and pram_rvalid at T+3, each with its own data.
- Reset pulsed at T+1 after a dma read grant at T -> no dma_rvalid ever appears; all outputs read 0 during reset.
